// File: rtl/reg_us_pkg.sv
// Shared definitions for the reg_us shift/rotate register: operation codes,
// FSM state encoding and a mode classification helper.
package reg_us_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_CLEAR = 3'b010,
        MODE_SHL   = 3'b011,
        MODE_SHR   = 3'b100,
        MODE_SAR   = 3'b101,
        MODE_ROL   = 3'b110,
        MODE_ROR   = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Codes 011..111 move bits; only these may start a multi-step operation.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m >= MODE_SHL);
    endfunction

endpackage

// File: rtl/reg_us_step.sv
// One-bit shift/rotate step. Non-shift modes pass the value through; the
// carry-out is only meaningful for the shift/rotate codes.
module reg_us_step
    import reg_us_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] r,
    input  logic [2:0]   mode,
    input  logic         sin,
    output logic [N-1:0] r_next,
    output logic         cout
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        r_next = r;
        cout   = 1'b0;
        case (mode)
            MODE_SHL: begin r_next = {r[N-2:0], sin};      cout = r[N-1]; end
            MODE_SHR: begin r_next = {sin, r[N-1:1]};      cout = r[0];   end
            MODE_SAR: begin r_next = {r[N-1], r[N-1:1]};   cout = r[0];   end
            MODE_ROL: begin r_next = {r[N-2:0], r[N-1]};   cout = r[N-1]; end
            MODE_ROR: begin r_next = {r[0], r[N-1:1]};     cout = r[0];   end
            default:  ;
        endcase
    end

endmodule

// File: rtl/reg_us.sv
// Universal shift register: single-cycle load/clear/shift/rotate, plus a
// counted multi-step shift sequenced by an IDLE/SHIFT/DONE FSM.
module reg_us
    import reg_us_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  data,
    input  logic [2:0]    mode,
    input  logic          en,
    input  logic          start,
    input  logic [CW-1:0] shamt,
    input  logic          sin,
    output logic [N-1:0]  reg_out,
    output logic          carry,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [N-1:0]  reg_q, reg_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    mode_q, mode_d;

    logic [2:0]    step_mode;
    logic [N-1:0]  step_r;
    logic          step_c;

    // One step unit serves both paths: live mode when idle, latched mode while shifting.
    assign step_mode = (state_q == ST_SHIFT) ? mode_q : mode;

    reg_us_step #(.N(N)) u_step (
        .r      (reg_q),
        .mode   (step_mode),
        .sin    (sin),
        .r_next (step_r),
        .cout   (step_c)
    );

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start && is_shift_mode(mode)) begin
                    mode_d  = mode;
                    cnt_d   = shamt;
                    state_d = ST_SHIFT;
                end else if (en) begin
                    case (mode)
                        MODE_HOLD:  ;
                        MODE_LOAD:  reg_d = data;
                        MODE_CLEAR: begin reg_d = '0; carry_d = 1'b0; end
                        default:    begin reg_d = step_r; carry_d = step_c; end
                    endcase
                end
            end
            ST_SHIFT: begin
                // A zero count still spends one SHIFT cycle, then completes without stepping.
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    reg_d   = step_r;
                    carry_d = step_c;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            reg_q   <= reg_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign reg_out = reg_q;
    assign carry   = carry_q;
    assign busy    = (state_q == ST_SHIFT);
    assign done    = (state_q == ST_DONE);

endmodule

// File: doc/reg_us.md
REG_US -- requirements
Module: reg_us

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning data/register width in bits (N >= 2).
REQ-002 The block SHALL have parameter CW, default 3, meaning shift-amount width in bits (2^CW - 1 >= N).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port data  input  N  parallel load value.
REQ-006 The block SHALL have port mode  input  3  operation code: 000 hold, 001 load, 010 clear, 011 SHL, 100 SHR logical, 101 SAR, 110 ROL, 111 ROR.
REQ-007 The block SHALL have port en  input  1  single-cycle operation enable.
REQ-008 The block SHALL have port start  input  1  multi-step shift request.
REQ-009 The block SHALL have port shamt  input  CW  multi-step shift count, sampled with start.
REQ-010 The block SHALL have port sin  input  1  serial fill bit for SHL (into bit 0) and SHR (into bit N-1).
REQ-011 The block SHALL have port reg_out  output  N  stored register value.
REQ-012 The block SHALL have port carry  output  1  last bit shifted or rotated out.
REQ-013 The block SHALL have port busy  output  1  multi-step shift in progress.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse at multi-step completion.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-016 In IDLE with en=1 and start=0, the mode operation SHALL apply once at the next edge: load reg_out<=data; clear reg_out<=0 and carry<=0; shift/rotate one bit; hold changes nothing.
REQ-017 Single-step semantics SHALL be: SHL {r[N-2:0],sin}, carry<=r[N-1]; SHR {sin,r[N-1:1]}, carry<=r[0]; SAR {r[N-1],r[N-1:1]}, carry<=r[0]; ROL {r[N-2:0],r[N-1]}, carry<=r[N-1]; ROR {r[0],r[N-1:1]}, carry<=r[0].
REQ-018 Load, clear and hold SHALL leave carry unchanged, except clear, which zeroes it.
REQ-019 In IDLE, start=1 with mode in 011..111 SHALL latch mode and shamt and enter SHIFT; busy SHALL rise the same edge.
REQ-020 start SHALL take priority over en in the same cycle; start with mode 000..010 SHALL be ignored, and en is then honoured.
REQ-021 In SHIFT, one latched-mode step SHALL execute per cycle, with the remaining count decremented; the block SHALL move to DONE after exactly shamt steps (latency shamt+1 edges from start to done).
REQ-022 start with shamt=0 SHALL go IDLE->SHIFT->DONE with no step executed, leaving reg_out and carry unchanged.
REQ-023 shamt > N SHALL execute literally (e.g. SHR fills entirely with sin; rotate wraps modulo N through repeated steps).
REQ-024 sin SHALL be sampled live on each step, not latched.
REQ-025 In DONE, done=1 and busy=0 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-026 While busy=1, en, start, mode, shamt and data SHALL be ignored.
REQ-027 start asserted in the DONE cycle SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL immediately force reg_out=0, carry=0, busy=0, done=0 and state IDLE, regardless of clk.
REQ-029 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse afterwards.
REQ-030 After rst_n deasserts, the first operation SHALL be accepted on the first posedge clk.

Structure
REQ-031 Mode codes and the FSM state encoding SHALL live in a shared package reg_us_pkg.
REQ-032 The one-bit step logic SHALL be a combinational sub-module reg_us_step (inputs r, mode, sin; outputs next value, carry-out), used by both the single-step and multi-step paths.

Verification
REQ-033 Reset, then en=1 mode=001 data=0xA -> reg_out=0xA next edge, carry=0, busy=0.
REQ-034 reg_out=0x9, en=1 mode=101 -> reg_out=0xC, carry=1; then mode=110 -> reg_out=0x9, carry=1.
REQ-035 reg_out=0x3, start=1 mode=011 shamt=2 sin=1 -> busy for 2 cycles, reg_out=0xF, carry=0, then done pulses one cycle.
REQ-036 start with shamt=0 -> done pulses 2 edges after start, reg_out and carry unchanged; start with mode=001 -> ignored and load occurs.
REQ-037 During SHIFT (shamt=5), toggle en/start/data -> no effect; assert rst_n=0 mid-shift -> reg_out=0 immediately, no done pulse.
REQ-038 N=8, CW=4, reg_out=0x81, ROR shamt=9 -> reg_out=0xC0, carry=1, done after 10 edges.
